// File: rtl/i2c_regfile_display.sv
// Pointer-addressed I2C register file with auto-increment, driving an
// N-digit multiplexed hex 7-segment display from the low register nibbles.
module i2c_regfile_display #(
  parameter int NUM_REGS   = 4,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1200,
  parameter int AUTO_INC   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i2c_start_i,
  input  logic                    i2c_read_i,
  input  logic [7:0]              i2c_rx_byte_data_i,
  input  logic                    i2c_rx_byte_valid_i,
  input  logic                    i2c_tx_req_i,
  output logic [7:0]              i2c_tx_byte_data_o,
  output logic                    i2c_tx_byte_valid_o,
  output logic [8*NUM_REGS-1:0]   regs_o,
  output logic                    ptr_err_o,
  output logic [6:0]              seg_pins_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o
);

  localparam int PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PTR_MAX    = PW'(NUM_REGS - 1);
  localparam logic [DW-1:0] IDX_MAX    = DW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(SCAN_DIV - 1);
  localparam logic [7:0]    NUM_REGS_B = 8'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PTR     = 3'd1,
    S_DATA    = 3'd2,
    S_DISCARD = 3'd3,
    S_RD      = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  err_q, err_d;
  logic [8*NUM_REGS-1:0] regs_q, regs_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [6:0]            seg_q, seg_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (AUTO_INC == 0) begin
      return p;
    end else if (p == PTR_MAX) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      4'hF: return 7'h71;
      default: return 7'h00;
    endcase
  endfunction

  // Transaction FSM, register writes and tx byte response.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    regs_d     = regs_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;

    // A start pre-empts any byte arriving in the same cycle.
    if (i2c_start_i) begin
      state_d = i2c_read_i ? S_RD : S_PTR;
    end else if (i2c_rx_byte_valid_i) begin
      case (state_q)
        S_PTR: begin
          if (i2c_rx_byte_data_i < NUM_REGS_B) begin
            ptr_d   = i2c_rx_byte_data_i[PW-1:0];
            err_d   = 1'b0;
            state_d = S_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_DATA: begin
          regs_d[{ptr_q, 3'b000} +: 8] = i2c_rx_byte_data_i;
          ptr_d = ptr_next(ptr_q);
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (i2c_tx_req_i) begin
      tx_valid_d = 1'b1;
      if (state_q == S_RD) begin
        tx_data_d = regs_q[{ptr_q, 3'b000} +: 8];
        ptr_d     = ptr_next(ptr_q);
      end else begin
        tx_data_d = 8'hFF;
      end
    end else begin
      tx_valid_d = 1'b0;
    end
  end

  // Digit scanner; segments and digit enable are computed from the next index
  // so both outputs change on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    sel_d = '0;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + DW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    sel_d[idx_d] = 1'b1;
    seg_d = hex7(regs_q[{idx_d, 2'b00} +: 4]);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      regs_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      sel_q      <= NUM_DIGITS'(1);
      seg_q      <= 7'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      regs_q     <= regs_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign i2c_tx_byte_data_o  = tx_data_q;
  assign i2c_tx_byte_valid_o = tx_valid_q;
  assign regs_o              = regs_q;
  assign ptr_err_o           = err_q;
  assign seg_pins_o          = seg_q;
  assign digit_sel_o         = sel_q;

endmodule

// File: doc/i2c_regfile_display.md
Name: i2c_regfile_display

Overview:
- Parametrised successor to the single-byte I2C-to-7-segment glue.
- Sits between the i2c_target byte-stream endpoints and an N-digit multiplexed 7-segment display.
- Implements a pointer-addressed register file with auto-increment that is writable and readable over I2C.
- Contains its own hex decoder and digit scanner; register contents drive the display directly.

Parameters:
- NUM_REGS, 4, number of 8-bit registers (2..16).
- NUM_DIGITS, 4, number of display digits (1..2*NUM_REGS).
- SCAN_DIV, 1200, clk cycles each digit stays selected (>=2).
- AUTO_INC, 1, 1 = pointer increments after each data byte; 0 = pointer holds.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i2c_start_i  in  1  one-cycle pulse from i2c_target on (repeated) START addressed to this target.
- i2c_read_i  in  1  R/W bit; sampled only when i2c_start_i=1 (1 = read).
- i2c_rx_byte_data_i  in  8  received byte.
- i2c_rx_byte_valid_i  in  1  one-cycle pulse; i2c_rx_byte_data_i valid.
- i2c_tx_req_i  in  1  one-cycle pulse; target needs the next read byte.
- i2c_tx_byte_data_o  out  8  byte returned to target.
- i2c_tx_byte_valid_o  out  1  one-cycle pulse; i2c_tx_byte_data_o valid.
- regs_o  out  8*NUM_REGS  flattened register file; reg k at [8k+7:8k].
- ptr_err_o  out  1  sticky; last pointer byte was out of range.
- seg_pins_o  out  7  segments {g,f,e,d,c,b,a}, active-high.
- digit_sel_o  out  NUM_DIGITS  one-hot digit enable, active-high.

Behaviour:
- Reset (async assert, sync release): all regs 0, ptr 0, ptr_err_o 0, FSM IDLE, i2c_tx_byte_valid_o 0, i2c_tx_byte_data_o 0, scan counter 0, digit_sel_o = 1 (digit 0), seg_pins_o 0.
- Reset mid-transaction aborts it with no partial write.

FSM states and transitions:
- IDLE: on start with read=0 → PTR; on start with read=1 → RD.
- PTR: next rx byte b.
  - If b < NUM_REGS: ptr = b, ptr_err_o = 0.
  - Else: ptr_err_o = 1 and the FSM enters DISCARD.
  - Either way, exit to DATA unless in error.
- DATA: each rx byte writes reg[ptr]. regs_o updates the cycle after rx_valid. If AUTO_INC, ptr = (ptr+1) mod NUM_REGS (wraps NUM_REGS-1 → 0).
- DISCARD: rx bytes ignored; tx requests return 0xFF.
- RD: each tx_req → next cycle i2c_tx_byte_valid_o = 1 and data = reg[ptr]. If AUTO_INC, ptr increments with the same wrap. A read with no prior pointer uses the retained ptr.
- Any i2c_start_i in any state re-enters PTR or RD per i2c_read_i. ptr is retained across transactions.
- Priority and stray events:
  - Start and rx_valid in the same cycle: start wins; the byte is discarded.
  - rx_valid while in RD, or tx_req outside RD/DISCARD: ignored. Outside RD/DISCARD, tx returns 0xFF with valid still pulsed (1-cycle latency).
- STOP needs no handling; the FSM simply remains in its state until the next start.

Display:
- digits = regs_o[4*NUM_DIGITS-1:0]; digit k shows nibble k.
- Scan counter counts 0..SCAN_DIV-1. On wrap, the digit index advances, wrapping NUM_DIGITS-1 → 0.
- seg_pins_o and digit_sel_o are registered; both update in the same cycle.
- A register write is visible on the segments within at most one scan period.
- Hex decode (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.

Test Plan:
- Write with NUM_REGS=4: start(w), bytes 01,AB,CD → reg1=AB, reg2=CD, ptr=3; regs_o=0x00CDAB00; ptr_err_o=0.
- Pointer wrap: start(w), 03,11,22 → reg3=11, reg0=22, ptr=1.
- Read back after the previous test: start(w), 00; start(r), three tx_req → tx bytes 22, AB, CD, each valid one cycle after its req.
- Bad pointer: start(w), 07,55 → no reg changes, ptr_err_o=1; tx_req then returns FF. A subsequent start(w),00 clears ptr_err_o.
- Display with reg0=0x21, SCAN_DIV=4: digit_sel_o steps 0001→0010→0100→1000→0001, one step every 4 cycles; seg_pins_o=06 on digit 0 and 5B on digit 1.
- Reset mid-write (rst_n low between rx bytes) → all regs 0, FSM IDLE. A following rx byte without a start causes no write.
